mul_div_unit: RTL

- Multi-cycle, parametrised HI/LO multiply/divide unit for the MIPS core; successor to the single-cycle HI/LO update in EX.
- Performs MULT, MULTU, DIV and DIVU iteratively, one bit per clock, and owns the HI/LO architectural registers.
- EX issues operations through a start/busy handshake and stalls MFHI/MFLO while busy=1.
- Handles signed operands, divide-by-zero and pipeline flush, none of which the previous generation did.

---
 rtl/mul_div_unit.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit: one shift-add or restoring shift-subtract
// step per clock, sign fix-up on the final edge, MTHI/MTLO written directly.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    localparam logic [2:0]       OP_MTHI = 3'd4;
    localparam logic [2:0]       OP_MTLO = 3'd5;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [WIDTH-1:0]       hi_q, hi_d;
    logic [WIDTH-1:0]       lo_q, lo_d;
    logic                   is_div_q, is_div_d;
    logic                   qneg_q, qneg_d;
    logic                   rneg_q, rneg_d;

    logic [WIDTH-1:0]       a_q, a_d;
    logic [WIDTH-1:0]       b_q, b_d;
    logic [WIDTH:0]         acc_q, acc_d;

    logic                   rs_neg, rt_neg;
    logic [WIDTH-1:0]       rs_mag, rt_mag;
    logic [WIDTH:0]         sum, mstep, shifted, diff;
    logic                   fits;
    logic [2*WIDTH-1:0]     product;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? (~v + (2*WIDTH)'(1)) : v;
    endfunction

    // Signed ops are the even opcodes; MIN's magnitude stays valid as unsigned 2^(WIDTH-1).
    assign rs_neg = !op[0] && rs[WIDTH-1];
    assign rt_neg = !op[0] && rt[WIDTH-1];
    assign rs_mag = cond_neg(rs, rs_neg);
    assign rt_mag = cond_neg(rt, rt_neg);

    assign sum     = acc_q + {1'b0, a_q};
    assign mstep   = b_q[0] ? sum : acc_q;
    assign shifted = {acc_q[WIDTH-1:0], b_q[WIDTH-1]};
    assign fits    = shifted >= {1'b0, a_q};
    assign diff    = shifted - {1'b0, a_q};
    assign product = cond_neg2({acc_q[WIDTH-1:0], b_q}, qneg_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;

        unique case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    if (!op[2]) begin
                        is_div_d = op[1];
                        // A zero divisor must leave the all-ones quotient unsigned.
                        qneg_d   = (rs_neg ^ rt_neg) && (rt != '0);
                        rneg_d   = rs_neg;
                        a_d      = op[1] ? rt_mag : rs_mag;
                        b_d      = op[1] ? rs_mag : rt_mag;
                        acc_d    = '0;
                        cnt_d    = '0;
                        busy_d   = 1'b1;
                        state_d  = RUN;
                    end else if (op == OP_MTHI) begin
                        hi_d = rs;
                    end else if (op == OP_MTLO) begin
                        lo_d = rs;
                    end
                end
            end
            RUN: begin
                if (flush) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (is_div_q) begin
                        acc_d = fits ? diff : shifted;
                        b_d   = {b_q[WIDTH-2:0], fits};
                    end else begin
                        acc_d = {1'b0, mstep[WIDTH:1]};
                        b_d   = {mstep[0], b_q[WIDTH-1:1]};
                    end
                    if (cnt_q == LAST) begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                busy_d  = 1'b0;
                state_d = IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        lo_d = cond_neg(b_q, qneg_q);
                        hi_d = cond_neg(acc_q[WIDTH-1:0], rneg_q);
                    end else begin
                        {hi_d, lo_d} = product;
                    end
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
        end
    end

    always_ff @(posedge CLK) begin
        a_q   <= a_d;
        b_q   <= b_d;
        acc_q <= acc_d;
    end

    assign busy = busy_q;
    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
